// File: rtl/regfile_writeback.sv
// Writeback stage: dual-request in-order write buffer draining one entry per cycle into a 64x16 register array.
// Optional read forwarding from the buffer is enabled by defining REGFILE_WB_BYPASS_EN.
module regfile_writeback #(
  parameter int DEPTH = 4,
  parameter int AW    = 6,
  parameter int DW    = 16
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     wr1_enable,
  input  logic [AW-1:0]            wr1,
  input  logic [DW-1:0]            wr1_data,
  input  logic                     wr2_enable,
  input  logic [AW-1:0]            wr2,
  input  logic [DW-1:0]            wr2_data,
  output logic                     stall,
  input  logic [AW-1:0]            rd1,
  input  logic [AW-1:0]            rd2,
  input  logic [AW-1:0]            rd3,
  output logic [DW-1:0]            rd1_out,
  output logic [DW-1:0]            rd2_out,
  output logic [DW-1:0]            rd3_out,
  output logic                     hazard,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;
  localparam int NREG = 1 << AW;

  logic [DW-1:0] mem      [NREG];
  logic [AW-1:0] buf_addr [DEPTH];
  logic [DW-1:0] buf_data [DEPTH];
  logic [PW-1:0] head, tail, slot2;
  logic          push1, push2, drain;

  assign stall = count > CW'(DEPTH - 2);
  assign push1 = !stall && wr1_enable;
  assign push2 = !stall && wr2_enable;
  assign drain = count != '0;
  // wr2 lands behind wr1 when both push, otherwise takes the tail slot itself
  assign slot2 = tail + PW'(push1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else begin
      if (drain) begin
        mem[buf_addr[head]] <= buf_data[head];
        head <= head + 1'b1;
      end
      tail  <= tail + PW'(push1) + PW'(push2);
      count <= count - CW'(drain) + CW'(push1) + CW'(push2);
    end
  end

  // Payload storage carries no reset; validity is defined by head/count.
  always_ff @(posedge clock) begin
    if (push1) begin
      buf_addr[tail] <= wr1;
      buf_data[tail] <= wr1_data;
    end
    if (push2) begin
      buf_addr[slot2] <= wr2;
      buf_data[slot2] <= wr2_data;
    end
  end

  logic [AW-1:0] rd_addr [3];
  logic [DW-1:0] rd_data [3];

  assign rd_addr[0] = rd1;
  assign rd_addr[1] = rd2;
  assign rd_addr[2] = rd3;
  assign rd1_out    = rd_data[0];
  assign rd2_out    = rd_data[1];
  assign rd3_out    = rd_data[2];

`ifdef REGFILE_WB_BYPASS_EN
  // Scan oldest to youngest so the youngest matching entry overrides.
  always_comb begin
    for (int p = 0; p < 3; p++) begin
      rd_data[p] = mem[rd_addr[p]];
      for (int k = 0; k < DEPTH; k++) begin
        if (CW'(k) < count && buf_addr[head + PW'(k)] == rd_addr[p])
          rd_data[p] = buf_data[head + PW'(k)];
      end
    end
  end

  assign hazard = 1'b0;
`else
  logic hazard_c;

  always_comb begin
    hazard_c = 1'b0;
    for (int p = 0; p < 3; p++) begin
      rd_data[p] = mem[rd_addr[p]];
      for (int k = 0; k < DEPTH; k++) begin
        if (CW'(k) < count && buf_addr[head + PW'(k)] == rd_addr[p])
          hazard_c = 1'b1;
      end
    end
  end

  assign hazard = hazard_c;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback; expectations follow REGFILE_WB_BYPASS_EN when it is defined.
module tb_regfile_writeback;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        wr1_enable, wr2_enable;
  logic [5:0]  wr1, wr2, rd1, rd2, rd3;
  logic [15:0] wr1_data, wr2_data;
  logic        stall, hazard;
  logic [15:0] rd1_out, rd2_out, rd3_out;
  logic [2:0]  count;

  int n_cmp = 0;
  int n_err = 0;

  regfile_writeback #(.DEPTH(4), .AW(6), .DW(16)) dut (
    .clock(clock), .reset_n(reset_n),
    .wr1_enable(wr1_enable), .wr1(wr1), .wr1_data(wr1_data),
    .wr2_enable(wr2_enable), .wr2(wr2), .wr2_data(wr2_data),
    .stall(stall),
    .rd1(rd1), .rd2(rd2), .rd3(rd3),
    .rd1_out(rd1_out), .rd2_out(rd2_out), .rd3_out(rd3_out),
    .hazard(hazard), .count(count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    wr1_enable = 1'b0;
    wr2_enable = 1'b0;
  endtask

  logic [5:0] exp_stall;
  int         p;

  initial begin
    reset_n = 1'b0;
    wr1_enable = 1'b0; wr2_enable = 1'b0;
    wr1 = '0; wr2 = '0; wr1_data = '0; wr2_data = '0;
    rd1 = 6'd0; rd2 = 6'd17; rd3 = 6'd63;
    #12 reset_n = 1'b1;
    #1;
    check("rst_count", count, 0);
    check("rst_stall", stall, 0);
    check("rst_hazard", hazard, 0);
    check("rst_r0", rd1_out, 16'h0000);
    check("rst_r17", rd2_out, 16'h0000);
    check("rst_r63", rd3_out, 16'h0000);

    // single write r5 = 0x1234
    wr1_enable = 1'b1; wr1 = 6'd5; wr1_data = 16'h1234; rd1 = 6'd5;
    tick();
    idle_inputs();
    check("single_count", count, 1);
`ifdef REGFILE_WB_BYPASS_EN
    check("single_fwd", rd1_out, 16'h1234);
    check("single_hazard", hazard, 0);
`else
    check("single_hazard", hazard, 1);
    check("single_mem_old", rd1_out, 16'h0000);
`endif
    tick();
    check("single_count_done", count, 0);
    check("single_hazard_done", hazard, 0);
    check("single_landed", rd1_out, 16'h1234);

    // same-address pair r9: 0xAAAA then 0x5555
    wr1_enable = 1'b1; wr1 = 6'd9; wr1_data = 16'hAAAA;
    wr2_enable = 1'b1; wr2 = 6'd9; wr2_data = 16'h5555; rd1 = 6'd9;
    tick();
    idle_inputs();
    check("pair_count", count, 2);
    check("pair_stall", stall, 0);
`ifdef REGFILE_WB_BYPASS_EN
    check("pair_fwd", rd1_out, 16'h5555);
`else
    check("pair_hazard", hazard, 1);
    check("pair_mem_old", rd1_out, 16'h0000);
`endif
    tick();
    check("pair_count1", count, 1);
`ifdef REGFILE_WB_BYPASS_EN
    check("pair_fwd1", rd1_out, 16'h5555);
`else
    check("pair_first_land", rd1_out, 16'hAAAA);
    check("pair_hazard1", hazard, 1);
`endif
    tick();
    check("pair_count0", count, 0);
    check("pair_final", rd1_out, 16'h5555);
    check("pair_hazard0", hazard, 0);

    // back-to-back pairs to r1..r8; stall pattern 0,0,1,0,1,0
    exp_stall = 6'b010100;
    p = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      wr1_enable = 1'b1; wr1 = 6'(2*p + 1); wr1_data = 16'(( 2*p + 1) * 16'h0101);
      wr2_enable = 1'b1; wr2 = 6'(2*p + 2); wr2_data = 16'((2*p + 2) * 16'h0101);
      check($sformatf("stream_stall_c%0d", cyc), stall, exp_stall[cyc]);
      tick();
      if (!exp_stall[cyc]) p++;
    end
    idle_inputs();
    check("stream_count_end", count, 3);
    tick(); tick(); tick();
    check("stream_drained", count, 0);
    for (int n = 1; n <= 8; n++) begin
      rd1 = 6'(n);
      #1;
      check($sformatf("stream_r%0d", n), rd1_out, 16'(n * 16'h0101));
    end

    // fill to count 3, then asynchronous reset mid-drain
    wr1_enable = 1'b1; wr1 = 6'd20; wr1_data = 16'h1111;
    wr2_enable = 1'b1; wr2 = 6'd21; wr2_data = 16'h2222;
    tick();
    wr1 = 6'd22; wr1_data = 16'h3333;
    wr2 = 6'd23; wr2_data = 16'h4444;
    tick();
    idle_inputs();
    check("fill_count", count, 3);
    check("fill_stall", stall, 1);
    rd1 = 6'd21; rd2 = 6'd22; rd3 = 6'd20;
    #2 reset_n = 1'b0;
    #1;
    check("arst_count", count, 0);
    check("arst_stall", stall, 0);
    check("arst_hazard", hazard, 0);
    check("arst_rd1", rd1_out, 16'h0000);
    check("arst_rd2", rd2_out, 16'h0000);
    check("arst_rd3", rd3_out, 16'h0000);
    tick(); tick();
    reset_n = 1'b1;
    tick(); tick();
    check("post_rst_count", count, 0);
    check("post_rst_r21", rd1_out, 16'h0000);
    check("post_rst_r22", rd2_out, 16'h0000);
    check("post_rst_r20", rd3_out, 16'h0000);
    rd1 = 6'd23; rd2 = 6'd9; rd3 = 6'd5;
    #1;
    check("post_rst_r23", rd1_out, 16'h0000);
    check("post_rst_r9", rd2_out, 16'h0000);
    check("post_rst_r5", rd3_out, 16'h0000);

    // pointer wrap: 10 single writes alternating r30/r31, odd ones via wr2 only
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) begin
        wr1_enable = 1'b1; wr1 = 6'd30; wr1_data = 16'(16'h0100 + i);
      end else begin
        wr2_enable = 1'b1; wr2 = 6'd31; wr2_data = 16'(16'h0100 + i);
      end
      rd2 = (i % 2 == 0) ? 6'd31 : 6'd30;
      tick();
      idle_inputs();
      check($sformatf("wrap_count_%0d", i), count, 1);
      if (i > 0)
        check($sformatf("wrap_land_%0d", i - 1), rd2_out, 16'(16'h0100 + i - 1));
    end
    tick();
    check("wrap_count_end", count, 0);
    rd1 = 6'd30;
    #1;
    check("wrap_r30", rd1_out, 16'h0108);
    rd1 = 6'd31;
    #1;
    check("wrap_r31", rd1_out, 16'h0109);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_writeback.md
# regfile_writeback

Writeback stage that sits directly downstream of the execute stage. It takes up to two register write requests per cycle (the execute stage's `wr1`/`wr2` ports) into a small in-order write buffer and drains them one per cycle into a 64 x 16-bit register array with a single physical write port. It serves the three register read ports (`rd1`..`rd3`) that feed execute, optionally forwarding values from the buffer, and backpressures execute with `stall` when the buffer cannot accept a full pair.

## Interface
- `DEPTH`, 4: write-buffer entries; power of two, at least 2
- `AW`, 6: register address width (64 registers)
- `DW`, 16: register data width

Ports:
- `clock`  in  1  sole clock; all state updates on its rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `wr1_enable`  in  1  write request 1 valid
- `wr1`  in  AW  write request 1 register address
- `wr1_data`  in  DW  write request 1 data
- `wr2_enable`  in  1  write request 2 valid; younger than request 1
- `wr2`  in  AW  write request 2 register address
- `wr2_data`  in  DW  write request 2 data
- `stall`  out  1  buffer cannot accept two writes; execute holds its requests
- `rd1`, `rd2`, `rd3`  in  AW  read addresses
- `rd1_out`, `rd2_out`, `rd3_out`  out  DW  read data, combinational from addresses and state
- `hazard`  out  1  a read address matches a buffered write (non-bypass build only)
- `count`  out  log2(DEPTH)+1  number of occupied buffer entries

## Operation
- State: register array `mem[0..63]`, circular buffer of `DEPTH` entries {addr, data}, head and tail pointers, and `count`.
- `stall` = (`count` > `DEPTH`-2). This is combinational from the current `count` only.
- Enqueue happens at an edge with `stall`=0:
  - `wr1_enable` pushes {`wr1`, `wr1_data`}.
  - `wr2_enable` then pushes {`wr2`, `wr2_data`} behind it.
  - If only `wr2_enable` is set, it occupies one slot.
- Requests presented while `stall`=1 are ignored and not queued. Execute must re-present them.
- Drain: at every edge where `count` > 0 before the edge, the head entry is written into `mem` and the head advances. The drain rate is exactly one per cycle.
- Count update: `count_next` = `count` - drain + number of pushes. Drain and enqueue are legal in the same cycle, including with the buffer at `DEPTH`-2 entries.
- Same address in `wr1` and `wr2` in one cycle: both are queued, and `wr2` lands last, so it wins.
- Pointers wrap modulo `DEPTH`. `count` never exceeds `DEPTH`.
- Reads: `rdN_out` = `mem[rdN]`, subject to forwarding (see Configuration). Write requests still on the input ports in the current cycle are never forwarded.
- Reset (asynchronous, at any time, including mid-drain):
  - `count`, head and tail = 0, and buffered entries are discarded.
  - All `mem` entries = 0.
  - Resulting outputs: `stall`=0, `hazard`=0, `rd*_out`=0.

## Timing
- A write accepted at edge T appears in `mem` no earlier than edge T+1. With k older entries queued, it lands at edge T+1+k.
- The second write of a pair lands one edge after the first.
- With forwarding, an accepted write is visible on the read ports immediately after edge T.
- `stall` rises in the cycle after `count` exceeds `DEPTH`-2. It falls after the drain brings `count` to `DEPTH`-2 or below. At the default `DEPTH` of 4 this means a steady stream of pairs stalls every second cycle.
- There is no other latency; read paths are purely combinational.

## Configuration
- `REGFILE_WB_BYPASS_EN` defined:
  - Each read port compares against all valid buffered entries. The youngest match wins over older matches, and any match wins over `mem`.
  - `hazard` is tied to 0.
- Not defined:
  - Read ports return `mem` only.
  - `hazard` = 1 whenever any `rdN` equals the address of any valid buffered entry. Execute must stall on `hazard`.

## Test plan
- Reset release → `count`=0, `stall`=0, `hazard`=0; reading r0, r17, r63 returns 0x0000.
- Single write r5=0x1234 at edge T:
  - Bypass build: `rd1_out`=0x1234 after T.
  - Non-bypass build: `hazard`=1 with `rd1`=5 until edge T+1, then `rd1_out`=0x1234 and `hazard`=0.
- Same-cycle pair r9=0xAAAA and r9=0x5555 → after two drains `mem[9]`=0x5555. The bypass build reads 0x5555 immediately after the accepting edge.
- Back-to-back pairs to r1..r8 at `DEPTH`=4:
  - `stall` pulses as described in Timing.
  - Pairs presented during `stall` are not lost once re-presented.
  - Final `mem[n]` = n*0x0101.
- Fill to `count`=3, assert `reset_n`=0 mid-drain → outputs go to reset values immediately, no buffered writes land, and `mem` stays all-zero.
- Pointer wrap: 10 single writes with alternating addresses → every value lands in order, and `count` returns to 0.
